qpu_exu_alu_arb: RTL and testbench

- Arbitrates the single shared ALU datapath (adder/comparator) between two requesters: the ALU arithmetic path (A) and the BJP branch-compare path (B).
- Round-robin grant; the granted operands and op-info drive the datapath combinationally.
- The result is captured in a one-entry output slot tagged with its owner, and returned on that owner's commit handshake.
- Also flags BJP mispredicts and keeps a saturating mispredict counter. Sits in the EXU between dispatch and commit.

---
 rtl/qpu_exu_alu_arb_pkg.sv | 36 +++
 rtl/qpu_rr_arb2.sv | 56 +++++
 rtl/qpu_exu_alu_arb.sv | 164 ++++++++++++++++
 tb/tb_qpu_exu_alu_arb.sv | 295 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/qpu_exu_alu_arb_pkg.sv
// Shared definitions for the EXU ALU/BJP datapath arbiter.
// Holds default widths, ALU opcode encodings, compare-select bit positions
// and the encodings of the result-slot state and round-robin owner.
package qpu_exu_alu_arb_pkg;

    localparam int QPU_XLEN  = 32;
    localparam int QPU_OPC_W = 4;
    localparam int QPU_CNT_W = 16;

    // ALU arithmetic opcodes; only the datapath interprets these
    localparam logic [QPU_OPC_W-1:0] ALU_OPC_ADD = 4'd0;
    localparam logic [QPU_OPC_W-1:0] ALU_OPC_SUB = 4'd1;
    localparam logic [QPU_OPC_W-1:0] ALU_OPC_AND = 4'd2;
    localparam logic [QPU_OPC_W-1:0] ALU_OPC_OR  = 4'd3;
    localparam logic [QPU_OPC_W-1:0] ALU_OPC_XOR = 4'd4;

    // Bit positions inside the one-hot {gt,lt,ne,eq} compare select
    localparam int BJP_CMP_EQ = 0;
    localparam int BJP_CMP_NE = 1;
    localparam int BJP_CMP_LT = 2;
    localparam int BJP_CMP_GT = 3;

    // One-entry result slot: empty, or holding a result for A or for B
    typedef enum logic [1:0] {
        SLOT_EMPTY  = 2'd0,
        SLOT_FULL_A = 2'd1,
        SLOT_FULL_B = 2'd2
    } slot_state_e;

    // Identity of the most recent grant winner
    typedef enum logic {
        GNT_A = 1'b0,
        GNT_B = 1'b1
    } gnt_owner_e;

endpackage

// File: rtl/qpu_rr_arb2.sv
// Two-way round-robin arbiter with a last-grant flop and grant enable.
// Latency: grants are combinational from req/en; history updates on the grant edge.
// Backpressure: en=0 suppresses both grants and freezes the history.
module qpu_rr_arb2
    import qpu_exu_alu_arb_pkg::*;
(
    input  logic clk,
    input  logic rst_n,
    input  logic en,
    input  logic req_a,
    input  logic req_b,
    output logic gnt_a,
    output logic gnt_b
);

    gnt_owner_e last_q;
    gnt_owner_e last_d;

    // Grant a lone requester; on a tie favour whoever did not win last time
    always_comb begin
        gnt_a = 1'b0;
        gnt_b = 1'b0;
        if (en) begin
            if (req_a && req_b) begin
                if (last_q == GNT_B) begin
                    gnt_a = 1'b1;
                end else begin
                    gnt_b = 1'b1;
                end
            end else begin
                gnt_a = req_a;
                gnt_b = req_b;
            end
        end
    end

    // History only moves when a grant is actually issued
    always_comb begin
        last_d = last_q;
        if (gnt_a) begin
            last_d = GNT_A;
        end else if (gnt_b) begin
            last_d = GNT_B;
        end
    end

    // History resets to B so that A takes the first tie
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            last_q <= GNT_B;
        end else begin
            last_q <= last_d;
        end
    end

endmodule

// File: rtl/qpu_exu_alu_arb.sv
// Shares one ALU adder/comparator between the ALU path (A) and BJP compare path (B).
// Latency: 1 cycle from request grant to owner's o_valid; 1 result/cycle with accept-and-drain.
// Backpressure: a held result (o_valid & !o_ready) blocks all new grants until it drains.
module qpu_exu_alu_arb
    import qpu_exu_alu_arb_pkg::*;
#(
    parameter int XLEN  = QPU_XLEN,
    parameter int OPC_W = QPU_OPC_W,
    parameter int CNT_W = QPU_CNT_W
) (
    input  logic             clk,
    input  logic             rst_n,

    input  logic             a_i_valid,
    output logic             a_i_ready,
    input  logic [XLEN-1:0]  a_i_op1,
    input  logic [XLEN-1:0]  a_i_op2,
    input  logic [OPC_W-1:0] a_i_opc,
    output logic             a_o_valid,
    input  logic             a_o_ready,
    output logic [XLEN-1:0]  a_o_res,

    input  logic             b_i_valid,
    output logic             b_i_ready,
    input  logic [XLEN-1:0]  b_i_op1,
    input  logic [XLEN-1:0]  b_i_op2,
    input  logic [3:0]       b_i_cmp,
    input  logic             b_i_prdt,
    output logic             b_o_valid,
    input  logic             b_o_ready,
    output logic             b_o_prdt,
    output logic             b_o_rslv,
    output logic             b_o_mispred,

    output logic [XLEN-1:0]  dp_op1,
    output logic [XLEN-1:0]  dp_op2,
    output logic [OPC_W-1:0] dp_opc,
    output logic             dp_cmp_eq,
    output logic             dp_cmp_ne,
    output logic             dp_cmp_lt,
    output logic             dp_cmp_gt,
    input  logic [XLEN-1:0]  dp_res,
    input  logic             dp_cmp_res,

    output logic [CNT_W-1:0] mispred_cnt,
    input  logic             mispred_clr
);

    slot_state_e      state_q, state_d;
    logic [XLEN-1:0]  a_res_q, a_res_d;
    logic             b_prdt_q, b_prdt_d;
    logic             b_rslv_q, b_rslv_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic a_drain;
    logic b_drain;
    logic slot_free;
    logic gnt_a;
    logic gnt_b;

    // The slot can take a new result when empty or when its owner consumes it this cycle
    always_comb begin
        a_drain   = (state_q == SLOT_FULL_A) && a_o_ready;
        b_drain   = (state_q == SLOT_FULL_B) && b_o_ready;
        slot_free = rst_n && ((state_q == SLOT_EMPTY) || a_drain || b_drain);
    end

    qpu_rr_arb2 u_arb (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (slot_free),
        .req_a (a_i_valid),
        .req_b (b_i_valid),
        .gnt_a (gnt_a),
        .gnt_b (gnt_b)
    );

    assign a_i_ready = slot_free && gnt_a;
    assign b_i_ready = slot_free && gnt_b;

    // Steer the granted requester onto the shared datapath; idle datapath sees zeros
    always_comb begin
        dp_op1    = '0;
        dp_op2    = '0;
        dp_opc    = '0;
        dp_cmp_eq = 1'b0;
        dp_cmp_ne = 1'b0;
        dp_cmp_lt = 1'b0;
        dp_cmp_gt = 1'b0;
        if (a_i_ready) begin
            dp_op1 = a_i_op1;
            dp_op2 = a_i_op2;
            dp_opc = a_i_opc;
        end else if (b_i_ready) begin
            dp_op1    = b_i_op1;
            dp_op2    = b_i_op2;
            dp_cmp_eq = b_i_cmp[BJP_CMP_EQ];
            dp_cmp_ne = b_i_cmp[BJP_CMP_NE];
            dp_cmp_lt = b_i_cmp[BJP_CMP_LT];
            dp_cmp_gt = b_i_cmp[BJP_CMP_GT];
        end
    end

    // Slot next state: drain first, then a same-cycle grant refills it
    always_comb begin
        state_d  = state_q;
        a_res_d  = a_res_q;
        b_prdt_d = b_prdt_q;
        b_rslv_d = b_rslv_q;
        if (a_drain || b_drain) begin
            state_d = SLOT_EMPTY;
        end
        if (a_i_ready) begin
            state_d = SLOT_FULL_A;
            a_res_d = dp_res;
        end else if (b_i_ready) begin
            state_d  = SLOT_FULL_B;
            b_prdt_d = b_i_prdt;
            b_rslv_d = dp_cmp_res;
        end
    end

    // Count mispredicts as they commit; clear wins, and the count sticks at all-ones
    always_comb begin
        cnt_d = cnt_q;
        if (mispred_clr) begin
            cnt_d = '0;
        end else if (b_drain && b_o_mispred && !(&cnt_q)) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    // Slot, captured result fields and counter; reset discards any held result
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= SLOT_EMPTY;
            a_res_q  <= '0;
            b_prdt_q <= 1'b0;
            b_rslv_q <= 1'b0;
            cnt_q    <= '0;
        end else begin
            state_q  <= state_d;
            a_res_q  <= a_res_d;
            b_prdt_q <= b_prdt_d;
            b_rslv_q <= b_rslv_d;
            cnt_q    <= cnt_d;
        end
    end

    assign a_o_valid   = (state_q == SLOT_FULL_A);
    assign a_o_res     = a_res_q;
    assign b_o_valid   = (state_q == SLOT_FULL_B);
    assign b_o_prdt    = b_prdt_q;
    assign b_o_rslv    = b_rslv_q;
    assign b_o_mispred = b_prdt_q ^ b_rslv_q;
    assign mispred_cnt = cnt_q;

`ifndef SYNTHESIS
    // A BJP request must select exactly one compare condition
    a_bjp_cmp_onehot: assert property (@(posedge clk) disable iff (!rst_n)
        b_i_valid |-> $onehot(b_i_cmp));
`endif

endmodule

// File: tb/tb_qpu_exu_alu_arb.sv
// Self-checking bench for qpu_exu_alu_arb with a transaction-level reference model.
module tb_qpu_exu_alu_arb;
    import qpu_exu_alu_arb_pkg::*;

    localparam int XLEN  = 32;
    localparam int OPC_W = 4;
    localparam int CNT_W = 16;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             a_i_valid, a_i_ready, a_o_valid, a_o_ready;
    logic [XLEN-1:0]  a_i_op1, a_i_op2, a_o_res;
    logic [OPC_W-1:0] a_i_opc;
    logic             b_i_valid, b_i_ready, b_i_prdt, b_o_valid, b_o_ready;
    logic [XLEN-1:0]  b_i_op1, b_i_op2;
    logic [3:0]       b_i_cmp;
    logic             b_o_prdt, b_o_rslv, b_o_mispred;
    logic [XLEN-1:0]  dp_op1, dp_op2, dp_res;
    logic [OPC_W-1:0] dp_opc;
    logic             dp_cmp_eq, dp_cmp_ne, dp_cmp_lt, dp_cmp_gt, dp_cmp_res;
    logic [CNT_W-1:0] mispred_cnt;
    logic             mispred_clr;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: who owns the slot, who won last, what it holds
    int               m_own;      // 0 none, 1 A, 2 B
    bit               m_last_b;
    logic [XLEN-1:0]  m_ares;
    bit               m_prdt, m_rslv;
    logic [CNT_W-1:0] m_cnt;
    bit               m_ga, m_gb;

    qpu_exu_alu_arb #(.XLEN(XLEN), .OPC_W(OPC_W), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst_n(rst_n),
        .a_i_valid(a_i_valid), .a_i_ready(a_i_ready), .a_i_op1(a_i_op1), .a_i_op2(a_i_op2),
        .a_i_opc(a_i_opc), .a_o_valid(a_o_valid), .a_o_ready(a_o_ready), .a_o_res(a_o_res),
        .b_i_valid(b_i_valid), .b_i_ready(b_i_ready), .b_i_op1(b_i_op1), .b_i_op2(b_i_op2),
        .b_i_cmp(b_i_cmp), .b_i_prdt(b_i_prdt), .b_o_valid(b_o_valid), .b_o_ready(b_o_ready),
        .b_o_prdt(b_o_prdt), .b_o_rslv(b_o_rslv), .b_o_mispred(b_o_mispred),
        .dp_op1(dp_op1), .dp_op2(dp_op2), .dp_opc(dp_opc),
        .dp_cmp_eq(dp_cmp_eq), .dp_cmp_ne(dp_cmp_ne), .dp_cmp_lt(dp_cmp_lt), .dp_cmp_gt(dp_cmp_gt),
        .dp_res(dp_res), .dp_cmp_res(dp_cmp_res),
        .mispred_cnt(mispred_cnt), .mispred_clr(mispred_clr)
    );

    always #5 clk = ~clk;

    function automatic logic [XLEN-1:0] ref_alu(input logic [OPC_W-1:0] opc,
                                                 input logic [XLEN-1:0] x, input logic [XLEN-1:0] y);
        case (opc)
            ALU_OPC_ADD: return x + y;
            ALU_OPC_SUB: return x - y;
            ALU_OPC_AND: return x & y;
            ALU_OPC_OR:  return x | y;
            ALU_OPC_XOR: return x ^ y;
            default:     return ~(x + y);
        endcase
    endfunction

    function automatic bit ref_cmp(input logic [3:0] c, input logic [XLEN-1:0] x, input logic [XLEN-1:0] y);
        return (c[0] && x == y) || (c[1] && x != y) || (c[2] && x < y) || (c[3] && x > y);
    endfunction

    // External datapath stub: combinational adder/comparator fed by the arbiter
    always_comb begin
        dp_res     = ref_alu(dp_opc, dp_op1, dp_op2);
        dp_cmp_res = ref_cmp({dp_cmp_gt, dp_cmp_lt, dp_cmp_ne, dp_cmp_eq}, dp_op1, dp_op2);
    end

    task automatic model_eval();
        bit free;
        free = rst_n && (m_own == 0 || (m_own == 1 && a_o_ready) || (m_own == 2 && b_o_ready));
        m_ga = free && a_i_valid && (!b_i_valid || m_last_b);
        m_gb = free && b_i_valid && (!a_i_valid || !m_last_b);
    endtask

    task automatic model_commit();
        bit drained;
        if (!rst_n) begin
            m_own = 0; m_last_b = 1; m_ares = '0; m_prdt = 0; m_rslv = 0; m_cnt = '0;
        end else begin
            drained = (m_own == 1 && a_o_ready) || (m_own == 2 && b_o_ready);
            if (mispred_clr) m_cnt = '0;
            else if (m_own == 2 && b_o_ready && (m_prdt != m_rslv) && m_cnt != {CNT_W{1'b1}}) m_cnt = m_cnt + 1;
            if (m_ga) begin
                m_own = 1; m_last_b = 0; m_ares = ref_alu(a_i_opc, a_i_op1, a_i_op2);
            end else if (m_gb) begin
                m_own = 2; m_last_b = 1; m_prdt = b_i_prdt; m_rslv = ref_cmp(b_i_cmp, b_i_op1, b_i_op2);
            end else if (drained) begin
                m_own = 0;
            end
        end
    endtask

    // Move to the falling edge with the model's grant prediction ready
    task automatic half_eval();
        model_eval();
        @(negedge clk);
    endtask

    // Clock edge, model update, then settle just after the edge
    task automatic half_commit();
        @(posedge clk);
        model_commit();
        #1;
    endtask

    task automatic idle_inputs();
        a_i_valid = 0; a_i_op1 = '0; a_i_op2 = '0; a_i_opc = '0; a_o_ready = 0;
        b_i_valid = 0; b_i_op1 = '0; b_i_op2 = '0; b_i_cmp = 4'b0001; b_i_prdt = 0; b_o_ready = 0;
        mispred_clr = 0;
    endtask

    task automatic do_reset();
        idle_inputs();
        rst_n = 0;
        half_eval();
        half_commit();
        rst_n = 1;
    endtask

    task automatic test_reset();
        idle_inputs();
        rst_n = 0; a_i_valid = 1; b_i_valid = 1; a_i_op1 = 32'h1234; b_i_op1 = 32'h55;
        half_eval();
        n_checks++; if ({a_i_ready, b_i_ready} !== 2'b00) begin n_fail++; $display("FAIL reset_readies: got %b want 00", {a_i_ready, b_i_ready}); end
        n_checks++; if ({dp_op1, dp_op2, dp_opc, dp_cmp_gt, dp_cmp_lt, dp_cmp_ne, dp_cmp_eq} !== '0) begin n_fail++; $display("FAIL reset_dp: got %h/%h/%h want 0", dp_op1, dp_op2, dp_opc); end
        half_commit();
        n_checks++; if ({a_o_valid, b_o_valid} !== 2'b00) begin n_fail++; $display("FAIL reset_ovalid: got %b want 00", {a_o_valid, b_o_valid}); end
        n_checks++; if (a_o_res !== '0) begin n_fail++; $display("FAIL reset_ares: got %h want 0", a_o_res); end
        n_checks++; if ({b_o_prdt, b_o_rslv, b_o_mispred} !== 3'b000) begin n_fail++; $display("FAIL reset_bout: got %b want 000", {b_o_prdt, b_o_rslv, b_o_mispred}); end
        n_checks++; if (mispred_cnt !== '0) begin n_fail++; $display("FAIL reset_cnt: got %h want 0", mispred_cnt); end
        rst_n = 1; idle_inputs();
    endtask

    task automatic test_single_a();
        a_i_valid = 1; a_i_op1 = 5; a_i_op2 = 3; a_i_opc = ALU_OPC_ADD;
        half_eval();
        n_checks++; if ({a_i_ready, b_i_ready} !== 2'b10) begin n_fail++; $display("FAIL single_a_rdy: got %b want 10", {a_i_ready, b_i_ready}); end
        n_checks++; if ({dp_op1, dp_op2, dp_opc, dp_cmp_gt, dp_cmp_lt, dp_cmp_ne, dp_cmp_eq} !== {32'd5, 32'd3, ALU_OPC_ADD, 4'b0000}) begin n_fail++; $display("FAIL single_a_dp: got %h %h %h want 5 3 0", dp_op1, dp_op2, dp_opc); end
        half_commit();
        a_i_valid = 0;
        n_checks++; if ({a_o_valid, b_o_valid} !== 2'b10) begin n_fail++; $display("FAIL single_a_ovld: got %b want 10", {a_o_valid, b_o_valid}); end
        n_checks++; if (a_o_res !== 32'd8) begin n_fail++; $display("FAIL single_a_res: got %0d want 8", a_o_res); end
        a_o_ready = 1;
        half_eval();
        half_commit();
        a_o_ready = 0;
        n_checks++; if ({a_o_valid, b_o_valid} !== 2'b00) begin n_fail++; $display("FAIL single_a_drain: got %b want 00", {a_o_valid, b_o_valid}); end
        n_checks++; if (a_o_res !== 32'd8) begin n_fail++; $display("FAIL single_a_hold: got %0d want 8", a_o_res); end
    endtask

    task automatic test_back_to_back();
        logic [XLEN-1:0] exp_res;
        do_reset();
        a_i_valid = 1; b_i_valid = 1; a_o_ready = 1; b_o_ready = 1;
        for (int i = 0; i < 8; i++) begin
            a_i_op1 = $urandom; a_i_op2 = $urandom; a_i_opc = OPC_W'($urandom_range(4, 0));
            b_i_op1 = $urandom; b_i_op2 = $urandom; b_i_cmp = 4'b0010;
            exp_res = ref_alu(a_i_opc, a_i_op1, a_i_op2);
            half_eval();
            n_checks++; if ({a_i_ready, b_i_ready} !== ((i % 2 == 0) ? 2'b10 : 2'b01)) begin n_fail++; $display("FAIL b2b_grant%0d: got %b", i, {a_i_ready, b_i_ready}); end
            half_commit();
            n_checks++; if ({a_o_valid, b_o_valid} !== ((i % 2 == 0) ? 2'b10 : 2'b01)) begin n_fail++; $display("FAIL b2b_ovld%0d: got %b", i, {a_o_valid, b_o_valid}); end
            if (i % 2 == 0) begin
                n_checks++; if (a_o_res !== exp_res) begin n_fail++; $display("FAIL b2b_res%0d: got %h want %h", i, a_o_res, exp_res); end
            end
        end
        idle_inputs(); a_o_ready = 1; b_o_ready = 1;
        half_eval(); half_commit();
        idle_inputs();
    endtask

    task automatic test_mispred();
        do_reset();
        for (int k = 0; k < 2; k++) begin
            b_i_valid = 1; b_i_op1 = 7; b_i_op2 = 7; b_i_cmp = 4'b0001; b_i_prdt = (k == 1);
            half_eval();
            n_checks++; if ({b_i_ready, dp_cmp_eq, dp_opc} !== {1'b1, 1'b1, 4'd0}) begin n_fail++; $display("FAIL mp_grant%0d: got rdy %b eq %b opc %h", k, b_i_ready, dp_cmp_eq, dp_opc); end
            half_commit();
            b_i_valid = 0;
            n_checks++; if ({b_o_valid, b_o_rslv, b_o_mispred} !== {1'b1, 1'b1, (k == 0)}) begin n_fail++; $display("FAIL mp_out%0d: got %b", k, {b_o_valid, b_o_rslv, b_o_mispred}); end
            n_checks++; if (mispred_cnt !== 16'd0 + k) begin n_fail++; $display("FAIL mp_cnt_pre%0d: got %0d", k, mispred_cnt); end
            b_o_ready = 1;
            half_eval(); half_commit();
            b_o_ready = 0;
            n_checks++; if (mispred_cnt !== 16'd1) begin n_fail++; $display("FAIL mp_cnt%0d: got %0d want 1", k, mispred_cnt); end
        end
    endtask

    task automatic test_hold();
        a_i_valid = 1; a_i_op1 = 10; a_i_op2 = 4; a_i_opc = ALU_OPC_SUB; a_o_ready = 0;
        half_eval(); half_commit();
        a_i_valid = 0; b_i_valid = 1; b_i_op1 = 1; b_i_op2 = 2; b_i_cmp = 4'b0010; b_i_prdt = 0;
        for (int i = 0; i < 4; i++) begin
            half_eval();
            n_checks++; if (b_i_ready !== 1'b0) begin n_fail++; $display("FAIL hold_brdy%0d: got %b want 0", i, b_i_ready); end
            half_commit();
            n_checks++; if ({a_o_valid, a_o_res} !== {1'b1, 32'd6}) begin n_fail++; $display("FAIL hold_ares%0d: got %b %0d want 1 6", i, a_o_valid, a_o_res); end
        end
        a_o_ready = 1;
        half_eval();
        n_checks++; if (b_i_ready !== 1'b1) begin n_fail++; $display("FAIL hold_accdrain: got %b want 1", b_i_ready); end
        half_commit();
        n_checks++; if ({a_o_valid, b_o_valid, b_o_rslv} !== 3'b011) begin n_fail++; $display("FAIL hold_after: got %b want 011", {a_o_valid, b_o_valid, b_o_rslv}); end
        idle_inputs(); b_o_ready = 1;
        half_eval(); half_commit();
        idle_inputs();
    endtask

    task automatic test_random();
        logic [71:0] exp_dp;
        for (int i = 0; i < 400; i++) begin
            a_i_valid = ($urandom_range(3, 0) != 0); b_i_valid = ($urandom_range(3, 0) != 0);
            a_o_ready = ($urandom_range(3, 0) != 0); b_o_ready = ($urandom_range(3, 0) != 0);
            a_i_op1 = $urandom; a_i_op2 = $urandom; a_i_opc = OPC_W'($urandom_range(7, 0));
            b_i_op1 = $urandom; b_i_op2 = ($urandom_range(1, 0) != 0) ? b_i_op1 : $urandom;
            b_i_cmp = 4'b0001 << $urandom_range(3, 0); b_i_prdt = $urandom_range(1, 0);
            mispred_clr = ($urandom_range(31, 0) == 0);
            half_eval();
            exp_dp = m_ga ? {a_i_op1, a_i_op2, a_i_opc, 4'b0000} : (m_gb ? {b_i_op1, b_i_op2, 4'b0000, b_i_cmp} : 72'd0);
            n_checks++; if ({a_i_ready, b_i_ready} !== {m_ga, m_gb}) begin n_fail++; $display("FAIL rnd_rdy%0d: got %b want %b", i, {a_i_ready, b_i_ready}, {m_ga, m_gb}); end
            n_checks++; if ({dp_op1, dp_op2, dp_opc, dp_cmp_gt, dp_cmp_lt, dp_cmp_ne, dp_cmp_eq} !== exp_dp) begin n_fail++; $display("FAIL rnd_dp%0d: got %h want %h", i, {dp_op1, dp_op2, dp_opc, dp_cmp_gt, dp_cmp_lt, dp_cmp_ne, dp_cmp_eq}, exp_dp); end
            half_commit();
            n_checks++; if ({a_o_valid, b_o_valid} !== {m_own == 1, m_own == 2}) begin n_fail++; $display("FAIL rnd_ovld%0d: got %b want owner %0d", i, {a_o_valid, b_o_valid}, m_own); end
            n_checks++; if (a_o_res !== m_ares) begin n_fail++; $display("FAIL rnd_ares%0d: got %h want %h", i, a_o_res, m_ares); end
            n_checks++; if ({b_o_prdt, b_o_rslv, b_o_mispred} !== {m_prdt, m_rslv, m_prdt ^ m_rslv}) begin n_fail++; $display("FAIL rnd_bout%0d: got %b want %b", i, {b_o_prdt, b_o_rslv, b_o_mispred}, {m_prdt, m_rslv, m_prdt ^ m_rslv}); end
            n_checks++; if (mispred_cnt !== m_cnt) begin n_fail++; $display("FAIL rnd_cnt%0d: got %0d want %0d", i, mispred_cnt, m_cnt); end
        end
        idle_inputs(); a_o_ready = 1; b_o_ready = 1;
        half_eval(); half_commit();
        idle_inputs();
    endtask

    task automatic test_saturate();
        do_reset();
        b_i_valid = 1; b_i_op1 = 1; b_i_op2 = 1; b_i_cmp = 4'b0001; b_i_prdt = 0; b_o_ready = 1;
        // Edge k captures one mispredict and drains the previous one: k-1 drains after k edges
        for (int k = 1; k <= 65539; k++) begin
            half_eval(); half_commit();
            if (k == 65535) begin
                n_checks++; if (mispred_cnt !== 16'hFFFE) begin n_fail++; $display("FAIL sat_near: got %h want fffe", mispred_cnt); end
            end
        end
        n_checks++; if (mispred_cnt !== 16'hFFFF) begin n_fail++; $display("FAIL sat_top: got %h want ffff", mispred_cnt); end
        n_checks++; if (mispred_cnt !== m_cnt) begin n_fail++; $display("FAIL sat_model: got %h want %h", mispred_cnt, m_cnt); end
        b_i_valid = 0; mispred_clr = 1;
        half_eval();
        n_checks++; if ({b_o_valid, b_o_mispred} !== 2'b11) begin n_fail++; $display("FAIL sat_clrsetup: got %b want 11", {b_o_valid, b_o_mispred}); end
        half_commit();
        mispred_clr = 0;
        n_checks++; if (mispred_cnt !== 16'd0) begin n_fail++; $display("FAIL sat_clr: got %h want 0", mispred_cnt); end
        idle_inputs();
    endtask

    task automatic test_reset_mid();
        b_i_valid = 1; b_i_op1 = 3; b_i_op2 = 9; b_i_cmp = 4'b0100; b_i_prdt = 0; b_o_ready = 1;
        half_eval(); half_commit();
        half_eval(); half_commit();
        b_i_valid = 0; b_o_ready = 0;
        half_eval(); half_commit();
        n_checks++; if ({b_o_valid, mispred_cnt} !== {1'b1, 16'd1}) begin n_fail++; $display("FAIL rmid_pre: got %b %0d want 1 1", b_o_valid, mispred_cnt); end
        rst_n = 0; a_i_valid = 1; b_i_valid = 1;
        half_eval();
        n_checks++; if ({a_i_ready, b_i_ready} !== 2'b00) begin n_fail++; $display("FAIL rmid_rdy: got %b want 00", {a_i_ready, b_i_ready}); end
        half_commit();
        rst_n = 1;
        n_checks++; if ({a_o_valid, b_o_valid, b_o_prdt, b_o_rslv, b_o_mispred} !== 5'b0) begin n_fail++; $display("FAIL rmid_out: got %b want 00000", {a_o_valid, b_o_valid, b_o_prdt, b_o_rslv, b_o_mispred}); end
        n_checks++; if (mispred_cnt !== 16'd0) begin n_fail++; $display("FAIL rmid_cnt: got %0d want 0", mispred_cnt); end
        half_eval();
        n_checks++; if ({a_i_ready, b_i_ready} !== 2'b10) begin n_fail++; $display("FAIL rmid_tie: got %b want 10", {a_i_ready, b_i_ready}); end
        half_commit();
        idle_inputs();
    endtask

    initial begin
        idle_inputs();
        rst_n = 0;
        m_own = 0; m_last_b = 1; m_ares = '0; m_prdt = 0; m_rslv = 0; m_cnt = '0; m_ga = 0; m_gb = 0;
        @(posedge clk); #1;
        test_reset();
        test_single_a();
        test_back_to_back();
        test_mispred();
        test_hold();
        test_random();
        test_saturate();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
